pwm_referencia: RTL
===================

PWM_REFERENCIA -- requirements
Module: pwm_referencia

Interface
REQ-001 Parameter W, default 9: width of reference, duty and period counter.
REQ-002 Parameter STEP, default 8: soft-start increment per PWM period (used only when SOFT_START_EN is defined).
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 en  input  1  run enable; low forces idle.
REQ-006 ref_in  input  W  validated reference from the upstream validation/register stage.
REQ-007 ref_valid  input  1  one-cycle strobe; ref_in is sampled when high.
REQ-008 pwm_out  output  1  registered PWM output.
REQ-009 period_end  output  1  registered one-cycle pulse, first cycle of each new period.
REQ-010 pending  output  1  high while a loaded reference has not yet been applied.
REQ-011 duty  output  W  active duty value currently being compared.

Function
REQ-012 Counter cnt SHALL count 0..2^W-1 and wrap to 0, giving a period of 2^W cycles (512 at W=9).
REQ-013 Shadow register SHALL load ref_in on any edge with ref_valid=1 and en=1, independent of cnt.
REQ-014 duty SHALL update only on the wrap edge (cnt = 2^W-1), taking the shadow value held before that edge.
REQ-015 ref_valid on the wrap edge SHALL write shadow only; that value is applied one full period later.
REQ-016 pwm_out(t+1) SHALL equal (cnt(t) < duty(t)), unsigned compare, one-cycle latency.
REQ-017 duty=0 SHALL give pwm_out constantly low; duty=2^W-1 SHALL give 2^W-1 high cycles out of 2^W.
REQ-018 period_end(t+1) SHALL be 1 only when cnt(t) = 2^W-1 and en=1.
REQ-019 pending SHALL set on ref_valid and clear on the wrap edge, unless ref_valid occurs on that same edge, in which case it stays set.
REQ-020 en=0 SHALL hold cnt at 0, force pwm_out, period_end and duty to 0, ignore ref_valid, and keep shadow and pending.
REQ-021 On the en 0->1 transition the counter SHALL start at 0, and duty SHALL take the shadow value at the first wrap.

Reset
REQ-022 reset=1 SHALL clear cnt, shadow, duty, pwm_out, period_end and pending to 0 on the next clock edge.
REQ-023 reset SHALL have priority over en and ref_valid.
REQ-024 Reset asserted mid-period SHALL abort the period; counting restarts from 0 after release.

Configuration
REQ-025 Macro SOFT_START_EN defined: at each wrap edge, if shadow > duty, duty SHALL become min(duty+STEP, shadow) with no overflow beyond shadow; if shadow <= duty, duty SHALL become shadow at once.
REQ-026 Under SOFT_START_EN, pending SHALL stay high until duty equals shadow.
REQ-027 Macro SOFT_START_EN undefined: duty SHALL become shadow at every wrap edge (REQ-014), and STEP SHALL be unused.

Verification (W=9, STEP=8)
REQ-028 Reset test: hold reset 3 cycles mid-run -> pwm_out=0, period_end=0, pending=0, duty=0 on the cycle after the edge.
REQ-029 Load ref_in=128 at cnt=10 -> pending=1; pwm_out stays low for the rest of that period; the next period has exactly 128 high cycles then 384 low; pending clears at the wrap.
REQ-030 Extremes: ref 0 -> pwm_out low for a whole period; ref 511 -> 511 high and 1 low per period; period_end pulses every 512 cycles.
REQ-031 Coincident load: ref_valid with ref_in=200 at cnt=511 -> the following period uses the old duty, the period after uses 200, and pending stays set across the first wrap.
REQ-032 SOFT_START_EN: shadow=40 from duty 0 -> duty 8,16,24,32,40 over 5 periods, then a load of 10 -> duty 10 at the next wrap. Without the macro, duty goes to 40 at the first wrap.
REQ-033 en toggle: drop en at cnt=300 -> pwm_out=0 the next cycle and shadow retained; raise en -> cnt restarts at 0 and the shadow is applied at the first wrap.

Source files
------------

// File: rtl/pwm_referencia.sv
// PWM generator with a double-buffered duty reference: loads land in a shadow
// register and are applied at the period wrap. Optional macro SOFT_START_EN ramps duty upward by STEP per period.
module pwm_referencia #(
    parameter int W    = 9,
    parameter int STEP = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] ref_in,
    input  logic         ref_valid,
    output logic         pwm_out,
    output logic         period_end,
    output logic         pending,
    output logic [W-1:0] duty
);

    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W:0]   STEP_V  = (W+1)'(STEP);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] shadow_q, shadow_d;
    logic [W-1:0] duty_q, duty_d;
    logic         pwm_q, pwm_d;
    logic         period_end_q, period_end_d;
    logic         pending_q, pending_d;

    logic         wrap;
    logic [W-1:0] duty_wrap;

    assign wrap = (cnt_q == CNT_MAX);

`ifdef SOFT_START_EN
    logic [W:0] gap;

    // Upward moves are limited to STEP per period and never overshoot the
    // shadow; downward moves are taken in one go.
    always_comb begin
        gap = {1'b0, shadow_q} - {1'b0, duty_q};
        if ((shadow_q > duty_q) && (gap > STEP_V)) begin
            duty_wrap = duty_q + STEP_V[W-1:0];
        end else begin
            duty_wrap = shadow_q;
        end
    end
`else
    logic unused_step;

    assign unused_step = ^STEP_V;
    assign duty_wrap   = shadow_q;
`endif

    always_comb begin
        cnt_d        = cnt_q;
        shadow_d     = shadow_q;
        duty_d       = duty_q;
        pwm_d        = pwm_q;
        period_end_d = period_end_q;
        pending_d    = pending_q;

        if (!en) begin
            // Idle: shadow and pending survive so a staged reference is not lost.
            cnt_d        = '0;
            duty_d       = '0;
            pwm_d        = 1'b0;
            period_end_d = 1'b0;
        end else begin
            cnt_d        = cnt_q + 1'b1;
            pwm_d        = (cnt_q < duty_q);
            period_end_d = wrap;
            if (ref_valid) begin
                shadow_d = ref_in;
            end
            if (wrap) begin
                duty_d    = duty_wrap;
                pending_d = ref_valid | (duty_wrap != shadow_q);
            end else if (ref_valid) begin
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            shadow_q     <= '0;
            duty_q       <= '0;
            pwm_q        <= 1'b0;
            period_end_q <= 1'b0;
            pending_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            duty_q       <= duty_d;
            pwm_q        <= pwm_d;
            period_end_q <= period_end_d;
            pending_q    <= pending_d;
        end
    end

    assign pwm_out    = pwm_q;
    assign period_end = period_end_q;
    assign pending    = pending_q;
    assign duty       = duty_q;

endmodule
